// File: rtl/transpose_pingpong.sv
// Two-bank transpose buffer: rows of S lanes go in, columns come out, one bank fills while the other drains.
// Optional macro TPOSE_FLUSH_EN adds a flush input that discards a partially written block.
module transpose_pingpong #(
  parameter int N     = 32,
  parameter int WIDTH = 21
) (
  input  logic               clk,
  input  logic               rst,
`ifdef TPOSE_FLUSH_EN
  input  logic               flush,
`endif
  input  logic [1:0]         size,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N*WIDTH-1:0] out_data,
  output logic               out_last
);
  localparam int RW = $clog2(N);
  localparam int SW = RW + 1;

  logic [WIDTH-1:0] mem_q [2][N][N];
  logic [1:0]       full_q, full_d;
  logic [SW-1:0]    sb_q [2];
  logic [SW-1:0]    sb_d [2];
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [RW-1:0]    wr_row_q, wr_row_d;
  logic [RW-1:0]    rd_col_q, rd_col_d;
  logic             flush_s;
  logic [SW-1:0]    wr_s, rd_s;
  logic             wr_en, wr_end, rd_en, rd_end;

  // Block size code to lane count, clamped to the buffer dimension.
  function automatic logic [SW-1:0] size_to_lanes(input logic [1:0] code);
    logic [6:0] raw;
    case (code)
      2'b00:   raw = 7'd4;
      2'b01:   raw = 7'd8;
      2'b10:   raw = 7'd16;
      2'b11:   raw = 7'd32;
      default: raw = 7'd32;
    endcase
    return (raw > 7'(N)) ? SW'(N) : SW'(raw);
  endfunction

`ifdef TPOSE_FLUSH_EN
  assign flush_s = flush;
`else
  assign flush_s = 1'b0;
`endif

  // Next-state logic for the write and read pointers, bank full flags and size latches.
  always_comb begin
    full_d    = full_q;
    sb_d      = sb_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_row_d  = wr_row_q;
    rd_col_d  = rd_col_q;
    // The size input only matters on a block's first row; later rows use the latch.
    wr_s   = (wr_row_q == '0) ? size_to_lanes(size) : sb_q[wr_bank_q];
    rd_s   = sb_q[rd_bank_q];
    wr_en  = in_valid && !full_q[wr_bank_q] && !flush_s;
    wr_end = ({1'b0, wr_row_q} == (wr_s - SW'(1)));
    rd_en  = full_q[rd_bank_q] && out_ready;
    rd_end = ({1'b0, rd_col_q} == (rd_s - SW'(1)));
    if (flush_s) begin
      wr_row_d = '0;
    end else if (wr_en) begin
      sb_d[wr_bank_q] = wr_s;
      if (wr_end) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_row_d          = '0;
      end else begin
        wr_row_d = wr_row_q + RW'(1);
      end
    end else begin
      wr_row_d = wr_row_q;
    end
    if (rd_en) begin
      if (rd_end) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = !rd_bank_q;
        rd_col_d          = '0;
      end else begin
        rd_col_d = rd_col_q + RW'(1);
      end
    end else begin
      rd_col_d = rd_col_q;
    end
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= 2'b00;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_row_q  <= '0;
      rd_col_q  <= '0;
      sb_q[0]   <= SW'(N);
      sb_q[1]   <= SW'(N);
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      sb_q      <= sb_d;
    end
  end

  // Sample storage; never reset, only the active lanes of an accepted row are written.
  always_ff @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (!rst && wr_en && (SW'(k) < wr_s)) begin
        mem_q[wr_bank_q][wr_row_q][k] <= in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Handshake and column outputs, forced to their idle values while reset is held.
  always_comb begin
    in_ready  = rst || !full_q[wr_bank_q];
    out_valid = !rst && full_q[rd_bank_q];
    out_last  = out_valid && rd_end;
    out_data  = '0;
    for (int r = 0; r < N; r++) begin
      if (out_valid && (SW'(r) < rd_s)) begin
        out_data[r*WIDTH +: WIDTH] = mem_q[rd_bank_q][r][rd_col_q];
      end else begin
        out_data[r*WIDTH +: WIDTH] = '0;
      end
    end
  end

endmodule

// File: tb/tb_transpose_pingpong.sv
// Directed bench for transpose_pingpong: row blocks with formula-derived contents, expected columns queued per block.
module tb_transpose_pingpong;
  localparam int N     = 32;
  localparam int WIDTH = 21;

  typedef struct packed {
    logic [N*WIDTH-1:0] data;
    logic [1:0]         sz;
  } row_t;

  typedef struct packed {
    logic [N*WIDTH-1:0] data;
    logic               last;
  } col_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  logic [1:0]         size;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [N*WIDTH-1:0] out_data;
  logic               out_last;

  row_t rows[$];
  col_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   chk_rdy = 1'b0;

  transpose_pingpong #(.N(N), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef TPOSE_FLUSH_EN
    .flush     (flush),
`endif
    .size      (size),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [N*WIDTH-1:0] got, input logic [N*WIDTH-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Queue nrows input rows and, optionally, the s columns the block must produce.
  task automatic add_block(input int nrows, input int s, input logic [1:0] sz0, input logic [1:0] sz1,
                           input int sw_at, input int base, input int mul, input int kmul, input bit expect_cols);
    row_t rw;
    col_t cl;
    for (int r = 0; r < nrows; r++) begin
      rw.data = '0;
      rw.sz   = (r < sw_at) ? sz0 : sz1;
      for (int k = 0; k < N; k++)
        rw.data[k*WIDTH +: WIDTH] = (k < s) ? WIDTH'(base + mul*r + kmul*k) : WIDTH'(32'h15A5A + k);
      rows.push_back(rw);
    end
    if (expect_cols) begin
      for (int c = 0; c < s; c++) begin
        cl.data = '0;
        for (int r = 0; r < s; r++) cl.data[r*WIDTH +: WIDTH] = WIDTH'(base + mul*r + kmul*c);
        cl.last = (c == s - 1);
        exp_q.push_back(cl);
      end
    end
  endtask

  // One clock cycle: present the next row, score any column transfer, advance past the edge.
  task automatic step();
    col_t e;
    if (rows.size() > 0) begin
      in_valid = 1'b1;
      in_data  = rows[0].data;
      size     = rows[0].sz;
    end else begin
      in_valid = 1'b0;
      in_data  = '0;
    end
    #1;
    if (chk_rdy) check("in_ready_hold", in_ready, 1'b1);
    if (in_valid && in_ready) void'(rows.pop_front());
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_col", out_valid, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("col_data", out_data, e.data);
          check("col_last", out_last, e.last);
        end
      end
    end else begin
      check("idle_last", out_last, 1'b0);
      check("idle_data", out_data, '0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((rows.size() > 0 || exp_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_left", rows.size() + exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; flush = 1'b0; size = 2'b00; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_out_data", out_data, '0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1'b1);
    check("post_rst_out_valid", out_valid, 1'b0);

    // 8x8 block, element (r,k) = 10r+k; first column one cycle after the last row.
    out_ready = 1'b1;
    add_block(8, 8, 2'b01, 2'b01, 8, 0, 10, 1, 1'b1);
    for (int i = 0; i < 8; i++) step();
    check("t1_first_col_latency", out_valid, 1'b1);
    drain(20);

    // Three back-to-back 4x4 blocks: the write side never stalls.
    chk_rdy = 1'b1;
    add_block(4, 4, 2'b00, 2'b00, 4, 100, 10, 1, 1'b1);
    add_block(4, 4, 2'b00, 2'b00, 4, 200, 10, 1, 1'b1);
    add_block(4, 4, 2'b00, 2'b00, 4, 300, 10, 1, 1'b1);
    drain(30);
    chk_rdy = 1'b0;

    // Two 16x16 blocks with downstream stalled: both banks fill, then one is released.
    out_ready = 1'b0;
    add_block(16, 16, 2'b10, 2'b10, 16, 1000, 40, 1, 1'b1);
    add_block(16, 16, 2'b10, 2'b10, 16, 3000, 40, 1, 1'b1);
    n = 0;
    while (rows.size() > 0 && n < 40) begin
      step();
      n++;
    end
    check("t3_fill_cycles", n, 32);
    check("t3_both_full_ready", in_ready, 1'b0);
    check("t3_both_full_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_blocked", in_ready, 1'b0);
      step();
    end
    check("t3_release", in_ready, 1'b1);
    drain(30);

    // Size drops to 4 after 5 rows of a 32-row block; the block keeps S=32, the next uses S=4.
    add_block(32, 32, 2'b11, 2'b00, 5, 5000, 50, 1, 1'b1);
    add_block(4, 4, 2'b00, 2'b00, 4, 9000, 10, 1, 1'b1);
    drain(100);

    // Reset with one bank full and three rows of the next block written.
    out_ready = 1'b0;
    add_block(4, 4, 2'b00, 2'b00, 4, 700, 10, 1, 1'b1);
    add_block(3, 4, 2'b00, 2'b00, 4, 800, 10, 1, 1'b0);
    n = 0;
    while (rows.size() > 0 && n < 20) begin
      step();
      n++;
    end
    check("t5_pre_full", out_valid, 1'b1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("t5_under_rst_ready", in_ready, 1'b1);
    check("t5_under_rst_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("t5_after_rst_valid", out_valid, 1'b0);
    check("t5_after_rst_ready", in_ready, 1'b1);
    exp_q.delete();
    out_ready = 1'b1;
    add_block(4, 4, 2'b00, 2'b00, 4, 40000, 3, 2, 1'b1);
    drain(20);

`ifdef TPOSE_FLUSH_EN
    // Five rows, a flush that also drops its own row, then a clean 8-row block of 7s.
    add_block(5, 8, 2'b01, 2'b01, 8, 99, 0, 0, 1'b0);
    drain(20);
    flush    = 1'b1;
    in_valid = 1'b1;
    size     = 2'b01;
    in_data  = {N{21'h00055}};
    @(posedge clk);
    #1;
    flush = 1'b0;
    add_block(8, 8, 2'b01, 2'b01, 8, 7, 0, 0, 1'b1);
    drain(30);
    check("t6_no_extra", out_valid, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
